bshift_seq: RTL
===============

Name: bshift_seq

Overview:
- Sequencing controller for the barrel-shifter datapath. It owns the data register and drives the combinational barrel shifter. It issues one shift step every DIV system clocks, and a built-in tick counter replaces a divided clock.
- On start it loads a value, applies a programmed rotate N times, then pulses done. Software-level users see a simple start/busy/done handshake.

Parameters:
- WIDTH, 8, data width of shifted value
- SHW, 3, shift-amount width (log2 WIDTH)
- STEPS_W, 4, width of step count
- DIV, 4, system clocks per shift step (>=1)

Ports:
- bshift_seq_fsys  in  1  system clock, rising edge
- bshift_seq_rst  in  1  reset, synchronous, active-high
- bshift_seq_start  in  1  start request, sampled in IDLE only
- bshift_seq_data  in  WIDTH  initial value, captured on accepted start
- bshift_seq_amt  in  SHW  shift amount per step, captured on start
- bshift_seq_dir  in  1  0 = rotate left, 1 = rotate right; captured on start
- bshift_seq_steps  in  STEPS_W  number of steps, captured on start
- bshift_seq_abort  in  1  terminate run early
- bshift_seq_sh_in  out  WIDTH  shifter operand (= q)
- bshift_seq_sh_amt  out  SHW  latched amount
- bshift_seq_sh_dir  out  1  latched direction
- bshift_seq_sh_out  in  WIDTH  shifter result (combinational, same cycle)
- bshift_seq_q  out  WIDTH  current register value
- bshift_seq_remaining  out  STEPS_W  steps left
- bshift_seq_busy  out  1  high in RUN
- bshift_seq_done  out  1  one-cycle completion pulse

Behaviour:
- Clocking and reset:
  - Single clock bshift_seq_fsys. Reset is synchronous and active-high on bshift_seq_rst.
  - Reset forces: state=IDLE, q=0, remaining=0, sh_amt=0, sh_dir=0, tick=0, busy=0, done=0.
  - Reset mid-run is identical to reset; no done pulse is issued.
- Output mapping: sh_in = q combinationally. sh_amt/sh_dir come from latched registers.
- States: IDLE, RUN, DONE.
  - IDLE:
    - start=1 captures q<=data, amt, dir, remaining<=steps, tick<=0.
    - If steps==0, next state is DONE; otherwise next state is RUN.
    - start=0 holds everything.
  - RUN:
    - busy=1. tick counts 0..DIV-1.
    - At tick==DIV-1: q<=sh_out, remaining<=remaining-1, tick<=0. If remaining==1, next state is DONE.
    - start is ignored while in RUN.
  - DONE:
    - done=1 for exactly one cycle, busy=0, then unconditionally return to IDLE.
    - start is ignored while in DONE.
- Abort:
  - abort=1 in RUN gives next state IDLE. q, remaining and amt/dir hold their current values. No done pulse.
  - Abort and tick==DIV-1 in the same cycle: abort wins and q is not updated.
  - Abort in IDLE or DONE has no effect.
- Timing:
  - Start is accepted at edge k. Updates occur at edges k+D, k+2D, ..., k+N·D.
  - done is high in the cycle after edge k+N·D.
  - busy is high from edge k to edge k+N·D.
  - DIV=1 gives one shift per clock.
- Arithmetic: remaining decrements only on a shift step and never wraps, because the RUN exit happens at 1.
- steps==0: q=data, no shifter update, busy never asserts, done pulses the cycle after acceptance.
- Start presented on the same cycle as reset is discarded.

Test Plan:
Bench conditions: WIDTH=8, DIV=4, with a behavioural rotate model on sh_in/sh_amt/sh_dir -> sh_out.
1. Reset: rst=1 for 2 cycles -> q=00, remaining=0, busy=0, done=0, sh_amt=0, sh_dir=0.
2. Left rotate, data=81, amt=1, dir=0, steps=3 -> busy=1; q goes 03, 06, 0C at +4, +8, +12 clocks; remaining goes 2, 1, 0; done pulses one cycle after the +12 update; busy=0.
3. Right rotate, data=01, amt=2, dir=1, steps=2 -> q goes 40 then 10; done pulses once.
4. Zero steps, data=A5, steps=0 -> q=A5, busy stays 0, done pulses the next cycle, q unchanged afterward.
5. Abort:
   - Run scenario 2 and assert abort at +6 clocks -> q=03, remaining=2, busy=0, no done.
   - Abort coinciding with the +8 tick -> q stays 03.
   - A subsequent start is accepted normally.
6. Ignored start and mid-run reset:
   - Pulse start with data=FF during RUN -> ignored; the original sequence completes.
   - Assert rst at +5 clocks of a new run -> all outputs return to reset values the next cycle, with no done pulse.

Source files
------------

// File: rtl/bshift_seq.sv
// Sequencing controller for the barrel-shifter datapath: loads a value, then
// applies the latched rotate once every DIV clocks for the programmed step count.
module bshift_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHW     = 3,
  parameter int unsigned STEPS_W = 4,
  parameter int unsigned DIV     = 4
) (
  input  logic               bshift_seq_fsys,
  input  logic               bshift_seq_rst,
  input  logic               bshift_seq_start,
  input  logic [WIDTH-1:0]   bshift_seq_data,
  input  logic [SHW-1:0]     bshift_seq_amt,
  input  logic               bshift_seq_dir,
  input  logic [STEPS_W-1:0] bshift_seq_steps,
  input  logic               bshift_seq_abort,
  output logic [WIDTH-1:0]   bshift_seq_sh_in,
  output logic [SHW-1:0]     bshift_seq_sh_amt,
  output logic               bshift_seq_sh_dir,
  input  logic [WIDTH-1:0]   bshift_seq_sh_out,
  output logic [WIDTH-1:0]   bshift_seq_q,
  output logic [STEPS_W-1:0] bshift_seq_remaining,
  output logic               bshift_seq_busy,
  output logic               bshift_seq_done
);

  // Tick counter keeps at least one bit so DIV=1 still elaborates.
  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   q, q_next;
  logic [STEPS_W-1:0] remaining, remaining_next;
  logic [SHW-1:0]     amt, amt_next;
  logic               dir, dir_next;
  logic [TW-1:0]      tick, tick_next;

  always_ff @(posedge bshift_seq_fsys) begin
    if (bshift_seq_rst) begin
      state     <= IDLE;
      q         <= '0;
      remaining <= '0;
      amt       <= '0;
      dir       <= 1'b0;
      tick      <= '0;
    end else begin
      state     <= state_next;
      q         <= q_next;
      remaining <= remaining_next;
      amt       <= amt_next;
      dir       <= dir_next;
      tick      <= tick_next;
    end
  end

  always_comb begin
    state_next     = state;
    q_next         = q;
    remaining_next = remaining;
    amt_next       = amt;
    dir_next       = dir;
    tick_next      = tick;
    case (state)
      IDLE: begin
        if (bshift_seq_start) begin
          q_next         = bshift_seq_data;
          amt_next       = bshift_seq_amt;
          dir_next       = bshift_seq_dir;
          remaining_next = bshift_seq_steps;
          tick_next      = '0;
          state_next     = (bshift_seq_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort takes priority over a coinciding shift step.
        if (bshift_seq_abort) begin
          state_next = IDLE;
        end else if (tick == TICK_LAST) begin
          q_next         = bshift_seq_sh_out;
          remaining_next = remaining - STEPS_W'(1);
          tick_next      = '0;
          if (remaining == STEPS_W'(1)) begin
            state_next = DONE;
          end
        end else begin
          tick_next = tick + TW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bshift_seq_sh_in     = q;
  assign bshift_seq_sh_amt    = amt;
  assign bshift_seq_sh_dir    = dir;
  assign bshift_seq_q         = q;
  assign bshift_seq_remaining = remaining;
  assign bshift_seq_busy      = (state == RUN);
  assign bshift_seq_done      = (state == DONE);

endmodule
